sat_slice: RTL and testbench

Parametrised, pipelined, multi-channel saturating slicer, the successor to the fixed 48-to-16 saturator. It takes NCH signed accumulator words, optionally rounds, arithmetically shifts by a runtime amount, and saturates each one to OW bits. Per-channel sticky flags and event counters support firmware diagnostics. It sits between the motor-control MAC/filter accumulators and the PWM/current-loop consumers.

---
 rtl/sat_pkg.sv | 15 +
 rtl/sat_slice_lane.sv | 88 ++++++++
 rtl/sat_slice.sv | 63 ++++++
 tb/tb_sat_slice.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared constants and helpers for the saturating slicer.
// Rounding modes and the shift clamp used by every lane.
package sat_pkg;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  function automatic int unsigned clamp_sh(
    input int unsigned s,
    input int unsigned lim
  );
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/sat_slice_lane.sv
// One slicer channel: round, shift, saturate, and track
// saturation events for diagnostics.
module sat_slice_lane
  import sat_pkg::*;
#(
  parameter int IW  = 48,
  parameter int OW  = 16,
  parameter int SHW = 6,
  parameter int CW  = 16
) (
  input  logic           c,
  input  logic           rst_n,
  input  logic           ld,
  input  logic           en,
  input  logic [IW-1:0]  d,
  input  logic [SHW-1:0] sh,
  input  logic           rnd,
  input  logic           clr,
  output logic [OW-1:0]  q,
  output logic           sat,
  output logic           sticky,
  output logic [CW-1:0]  cnt
);

  localparam int W = IW + 1;

  logic signed [W-1:0] ext;
  logic signed [W-1:0] bias;
  logic signed [W-1:0] shd;
  logic [W-1:0]        s1;
  logic [IW-OW+1:0]    hi;
  logic                fits;
  logic [OW-1:0]       q_nx;
  logic                ev;

  always_comb begin
    ext  = $signed({d[IW-1], d});
    bias = '0;
    if (rnd == RND_HALF_UP && sh != '0)
      bias = W'(1) << (sh - SHW'(1));
    shd = (ext + bias) >>> sh;
  end

  // Fits when everything above the output sign bit matches it.
  always_comb begin
    hi   = s1[IW:OW-1];
    fits = (&hi) | ~(|hi);
    q_nx = s1[OW-1:0];
    if (!fits)
      q_nx = s1[IW] ? {1'b1, {(OW-1){1'b0}}}
                    : {1'b0, {(OW-1){1'b1}}};
    ev = en & ~fits;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (ld) begin
      s1 <= shd;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      q   <= q_nx;
      sat <= ~fits;
    end
  end

  // A clear still records an event landing on the same edge.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (clr) begin
      sticky <= ev;
      cnt    <= ev ? CW'(1) : '0;
    end else if (ev) begin
      sticky <= 1'b1;
      if (cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sat_slice.sv
// Multi-channel pipelined saturating slicer: shared valid
// pipeline and shift clamp, one lane per channel.
module sat_slice
  import sat_pkg::*;
#(
  parameter int NCH = 1,
  parameter int IW  = 48,
  parameter int OW  = 16,
  parameter int SHW = 6,
  parameter int CW  = 16
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [NCH*IW-1:0] in_d,
  input  logic [SHW-1:0]    sh,
  input  logic              rnd,
  input  logic              clr,
  output logic              out_valid,
  output logic [NCH*OW-1:0] out_q,
  output logic [NCH-1:0]    out_sat,
  output logic [NCH-1:0]    sat_sticky,
  output logic [NCH*CW-1:0] sat_cnt
);

  logic [SHW-1:0] sh_c;
  logic           v1;

  assign sh_c = SHW'(clamp_sh(32'(sh), IW - OW));

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1        <= in_valid;
      out_valid <= v1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    sat_slice_lane #(
      .IW (IW),
      .OW (OW),
      .SHW(SHW),
      .CW (CW)
    ) u_lane (
      .c     (c),
      .rst_n (rst_n),
      .ld    (in_valid),
      .en    (v1),
      .d     (in_d[k*IW +: IW]),
      .sh    (sh_c),
      .rnd   (rnd),
      .clr   (clr),
      .q     (out_q[k*OW +: OW]),
      .sat   (out_sat[k]),
      .sticky(sat_sticky[k]),
      .cnt   (sat_cnt[k*CW +: CW])
    );
  end

endmodule

// File: tb/tb_sat_slice.sv
// Randomised bench for sat_slice against an arithmetic
// reference model, plus directed boundary cases.
module tb_sat_slice;

  localparam int NCH = 4;
  localparam int IW  = 48;
  localparam int OW  = 16;
  localparam int SHW = 6;
  localparam int CW  = 4;

  logic              c = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [NCH*IW-1:0] in_d = '0;
  logic [SHW-1:0]    sh = '0;
  logic              rnd = 1'b0;
  logic              clr = 1'b0;
  logic              out_valid;
  logic [NCH*OW-1:0] out_q;
  logic [NCH-1:0]    out_sat;
  logic [NCH-1:0]    sat_sticky;
  logic [NCH*CW-1:0] sat_cnt;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit          m_ov;
  logic [15:0] m_q   [NCH];
  bit          m_sat [NCH];
  bit          m_stk [NCH];
  int          m_cnt [NCH];
  bit          p_v;
  logic [15:0] p_q   [NCH];
  bit          p_sat [NCH];

  sat_slice #(
    .NCH(NCH), .IW(IW), .OW(OW), .SHW(SHW), .CW(CW)
  ) dut (
    .c         (c),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_d      (in_d),
    .sh        (sh),
    .rnd       (rnd),
    .clr       (clr),
    .out_valid (out_valid),
    .out_q     (out_q),
    .out_sat   (out_sat),
    .sat_sticky(sat_sticky),
    .sat_cnt   (sat_cnt)
  );

  always #5 c = ~c;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_slice(
    input  logic [47:0] d,
    input  int          s,
    input  bit          r,
    output logic [15:0] q,
    output bit          st
  );
    longint v;
    int sc;
    v  = $signed({{16{d[47]}}, d});
    sc = (s > IW - OW) ? IW - OW : s;
    if (r && sc > 0) v += longint'(1) << (sc - 1);
    v = v >>> sc;
    st = 1'b1;
    if (v > 32767) q = 16'h7fff;
    else if (v < -32768) q = 16'h8000;
    else begin
      q  = 16'(v);
      st = 1'b0;
    end
  endfunction

  task automatic mreset();
    m_ov = 0;
    p_v  = 0;
    for (int k = 0; k < NCH; k++) begin
      m_q[k] = '0; m_sat[k] = 0; m_stk[k] = 0;
      m_cnt[k] = 0; p_q[k] = '0; p_sat[k] = 0;
    end
  endtask

  task automatic check_all();
    logic [63:0] eq, es, ek, ec;
    eq = '0; es = '0; ek = '0; ec = '0;
    for (int k = 0; k < NCH; k++) begin
      eq[k*OW +: OW] = m_q[k];
      es[k]          = m_sat[k];
      ek[k]          = m_stk[k];
      ec[k*CW +: CW] = CW'(m_cnt[k]);
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_q", 64'(out_q), eq);
    chk("out_sat", 64'(out_sat), es);
    chk("sticky", 64'(sat_sticky), ek);
    chk("cnt", 64'(sat_cnt), ec);
  endtask

  task automatic tick();
    bit ev;
    @(posedge c);
    if (!rst_n) mreset();
    else begin
      m_ov = p_v;
      for (int k = 0; k < NCH; k++) begin
        ev = p_v && p_sat[k];
        if (p_v) begin
          m_q[k]   = p_q[k];
          m_sat[k] = p_sat[k];
        end
        if (clr) begin
          m_stk[k] = ev;
          m_cnt[k] = ev ? 1 : 0;
        end else if (ev) begin
          m_stk[k] = 1;
          if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
        end
      end
      p_v = in_valid;
      if (in_valid)
        for (int k = 0; k < NCH; k++)
          ref_slice(in_d[k*IW +: IW], int'(sh), rnd,
                    p_q[k], p_sat[k]);
    end
    #1;
    check_all();
  endtask

  function automatic logic [47:0] rnd_word();
    logic signed [47:0] t;
    t = $signed({16'($urandom), 32'($urandom)});
    return t >>> $urandom_range(0, 47);
  endfunction

  // drive lane 0 with d0, other lanes random, and wait for output
  task automatic send_one(input logic [47:0] d0,
                          input int s, input bit r);
    for (int k = 1; k < NCH; k++) in_d[k*IW +: IW] = rnd_word();
    in_d[47:0] = d0;
    sh  = SHW'(s);
    rnd = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    mreset();
    tick();
    tick();
    chk("rst_q", 64'(out_q), 64'd0);
    #1 rst_n = 1'b1;
    tick();

    send_one(48'h0000_0012_3456, 8, 0);
    chk("legacy_q", 64'(out_q[15:0]), 64'h1234);
    chk("legacy_sat", 64'(out_sat[0]), 64'd0);
    send_one(48'h0000_8000_0000, 8, 0);
    chk("pos_sat_q", 64'(out_q[15:0]), 64'h7fff);
    chk("pos_sat", 64'(out_sat[0]), 64'd1);
    send_one(48'hFFFF_0000_0000, 8, 0);
    chk("neg_sat_q", 64'(out_q[15:0]), 64'h8000);
    send_one(48'h0000_0000_1280, 8, 1);
    chk("round_q", 64'(out_q[15:0]), 64'h0013);
    send_one(48'h0000_007F_FF80, 8, 1);
    chk("round_ovf_q", 64'(out_q[15:0]), 64'h7fff);
    chk("round_ovf_sat", 64'(out_sat[0]), 64'd1);
    tick();
    chk("hold_q", 64'(out_q[15:0]), 64'h7fff);

    // long saturating run: counter must stick at all-ones
    for (int k = 0; k < NCH; k++)
      in_d[k*IW +: IW] = 48'h0000_8000_0000;
    sh = 6'd8; rnd = 1'b0; in_valid = 1'b1;
    repeat (22) tick();
    chk("cnt_full", 64'(sat_cnt[3:0]), 64'hf);
    chk("sticky_full", 64'(sat_sticky[0]), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_event_cnt", 64'(sat_cnt[3:0]), 64'd1);
    chk("clr_event_stk", 64'(sat_sticky[0]), 64'd1);
    in_valid = 1'b0;
    repeat (3) tick();

    // random traffic with gaps, clamped shifts and clears
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCH; k++)
        in_d[k*IW +: IW] = rnd_word();
      in_valid = ($urandom_range(0, 2) != 0);
      sh  = ($urandom_range(0, 4) == 0) ? 6'd40 : 6'($urandom);
      rnd = 1'($urandom);
      clr = ($urandom_range(0, 24) == 0);
      tick();
    end
    clr = 1'b0;

    // reset with both stages occupied
    in_valid = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 mreset();
    check_all();
    chk("rst_mid_ov", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_cnt", 64'(sat_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
